// File: rtl/ks_decomp_seq_pkg.sv
// ----------------------------------------------------------------------------
// ks_decomp_seq_pkg
// Types, derived widths and the balanced-digit helper for the keyswitch
// input-decomposition stage.
// No ports; constants, typedefs and one function.
// ----------------------------------------------------------------------------
package ks_decomp_seq_pkg;

    import tfhe_param_pkg::*;

    localparam int KS_DECOMP_W = KS_L * KS_B_W;
    localparam int ROUND_BIT   = MOD_Q_W - KS_DECOMP_W - 1;
    localparam int IN_COEF_NB  = GLWE_K * POLY_N;
    localparam int LVL_W       = $clog2(KS_L);
    localparam int COEF_W      = $clog2(IN_COEF_NB);

    localparam logic [KS_B_W:0] HALF_B = (KS_B_W + 1)'(1 << (KS_B_W - 1));
    localparam logic [KS_B_W:0] FULL_B = (KS_B_W + 1)'(1 << KS_B_W);

    typedef logic signed [KS_B_W:0] digit_t;
    typedef logic [KS_B_W-1:0]      chunk_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef struct packed {
        digit_t digit;
        logic   carry;
    } digit_res_t;

    // Balanced digit: d = chunk + carry lies in 0..B. Values at or above B/2
    // are folded to d-B with a carry into the next, more significant level.
    function automatic digit_res_t balanced_digit(input chunk_t chunk, input logic carry_in);
        logic [KS_B_W:0] d;
        digit_res_t      res;
        d = {1'b0, chunk} + {{KS_B_W{1'b0}}, carry_in};
        if (d >= HALF_B) begin
            res.digit = $signed(d - FULL_B);
            res.carry = 1'b1;
        end else begin
            res.digit = $signed(d);
            res.carry = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/tfhe_param_pkg.sv
// ----------------------------------------------------------------------------
// tfhe_param_pkg
// Global TFHE parameter set shared by the keyswitch datapath blocks.
// No ports; constants only.
// ----------------------------------------------------------------------------
package tfhe_param_pkg;

    localparam int MOD_Q_W = 64;
    localparam int KS_L    = 8;
    localparam int KS_B_W  = 2;
    localparam int GLWE_K  = 1;
    localparam int POLY_N  = 2048;

endpackage

// File: rtl/ks_decomp_seq_if.sv
// ----------------------------------------------------------------------------
// ks_decomp_seq_if
// Input coefficient stream and output digit stream of the decomposition stage.
//   in_data/in_vld/in_rdy      : mask coefficient handshake
//   out_digit/out_lvl/out_coef : tagged balanced digit
//   out_last_lvl/out_last_coef : end-of-coefficient / end-of-ciphertext flags
//   out_vld/out_rdy            : digit handshake
// slave  : view of the decomposition block
// master : view of the surrounding logic (or a testbench)
// ----------------------------------------------------------------------------
interface ks_decomp_seq_if
    import tfhe_param_pkg::*, ks_decomp_seq_pkg::*;
();

    logic [MOD_Q_W-1:0] in_data;
    logic               in_vld;
    logic               in_rdy;
    digit_t             out_digit;
    logic [LVL_W-1:0]   out_lvl;
    logic [COEF_W-1:0]  out_coef;
    logic               out_last_lvl;
    logic               out_last_coef;
    logic               out_vld;
    logic               out_rdy;

    modport slave (
        input  in_data, in_vld, out_rdy,
        output in_rdy, out_digit, out_lvl, out_coef,
               out_last_lvl, out_last_coef, out_vld
    );

    modport master (
        output in_data, in_vld, out_rdy,
        input  in_rdy, out_digit, out_lvl, out_coef,
               out_last_lvl, out_last_coef, out_vld
    );

endinterface

// File: rtl/ks_decomp_digit.sv
// ----------------------------------------------------------------------------
// ks_decomp_digit
// Combinational single-level balanced digit generator.
//   chunk     in  KS_B_W   base-B chunk of the rounded coefficient
//   carry_in  in  1        carry from the less significant level
//   digit     out KS_B_W+1 signed digit in [-B/2, B/2-1]
//   carry_out out 1        carry into the more significant level
// ----------------------------------------------------------------------------
module ks_decomp_digit
    import tfhe_param_pkg::*, ks_decomp_seq_pkg::*;
(
    input  chunk_t chunk,
    input  logic   carry_in,
    output digit_t digit,
    output logic   carry_out
);

    digit_res_t res;

    always_comb begin
        res = balanced_digit(chunk, carry_in);
    end

    assign digit     = res.digit;
    assign carry_out = res.carry;

endmodule

// File: rtl/ks_decomp_seq.sv
// ----------------------------------------------------------------------------
// ks_decomp_seq
// Keyswitch input decomposition. Each accepted 64-bit mask coefficient is
// rounded to its KS_L*KS_B_W MSBs and emitted as KS_L balanced signed digits,
// least significant level first (out_lvl KS_L-1 down to 0), one per cycle,
// with back-to-back coefficients when the producer keeps in_vld high.
//   clk      in  clock
//   a_rst_n  in  asynchronous active-low reset
//   bus      ks_decomp_seq_if.slave, input and output streams
// ----------------------------------------------------------------------------
module ks_decomp_seq
    import tfhe_param_pkg::*, ks_decomp_seq_pkg::*;
(
    input logic            clk,
    input logic            a_rst_n,
    ks_decomp_seq_if.slave bus
);

    localparam logic [COEF_W-1:0] COEF_MAX  = COEF_W'(IN_COEF_NB - 1);
    localparam logic [LVL_W-1:0]  LVL_FIRST = LVL_W'(KS_L - 1);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);

    state_t                  state;
    logic [KS_DECOMP_W-1:0]  shreg;
    logic                    carry;
    digit_t                  digit_q;
    logic [LVL_W-1:0]        lvl_q;
    logic [COEF_W-1:0]       coef_q;
    logic                    last_lvl_q;
    logic                    vld_q;

    logic [KS_DECOMP_W-1:0]  rounded;
    logic                    last_hs;
    logic                    in_rdy;
    logic                    accept;
    logic                    advance;
    chunk_t                  chunk_sel;
    logic                    carry_sel;
    digit_t                  dig;
    logic                    cout;
    logic                    unused_low;

    // Round to nearest on the retained MSBs; the addition wraps so an all-ones
    // top field with the round bit set becomes zero.
    assign rounded = bus.in_data[MOD_Q_W-1 -: KS_DECOMP_W]
                   + KS_DECOMP_W'(bus.in_data[ROUND_BIT]);

    assign unused_low = ^bus.in_data[ROUND_BIT-1:0];

    // The last digit handing off frees the block in the same cycle, which is
    // what lets the next coefficient load with no bubble.
    assign last_hs = (state == EMIT) && last_lvl_q && bus.out_rdy;
    assign in_rdy  = (state == IDLE) || last_hs;
    assign accept  = bus.in_vld && in_rdy;
    assign advance = (state == EMIT) && bus.out_rdy && !last_lvl_q;

    // A newly accepted coefficient feeds its lowest chunk straight from the
    // rounder with a cleared carry; otherwise the shift register supplies it.
    assign chunk_sel = accept ? rounded[KS_B_W-1:0] : shreg[KS_B_W-1:0];
    assign carry_sel = accept ? 1'b0 : carry;

    ks_decomp_digit u_digit (
        .chunk     (chunk_sel),
        .carry_in  (carry_sel),
        .digit     (dig),
        .carry_out (cout)
    );

    // Sequencer: load on accept, shift one level per output handshake, and
    // drop back to IDLE after the level-0 digit if nothing is waiting.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            carry      <= 1'b0;
            digit_q    <= '0;
            lvl_q      <= '0;
            last_lvl_q <= 1'b0;
            vld_q      <= 1'b0;
        end else if (accept) begin
            state      <= EMIT;
            shreg      <= rounded >> KS_B_W;
            carry      <= cout;
            digit_q    <= dig;
            lvl_q      <= LVL_FIRST;
            last_lvl_q <= (KS_L == 1);
            vld_q      <= 1'b1;
        end else if (advance) begin
            shreg      <= shreg >> KS_B_W;
            carry      <= cout;
            digit_q    <= dig;
            lvl_q      <= lvl_q - LVL_ONE;
            last_lvl_q <= (lvl_q == LVL_ONE);
        end else if (last_hs) begin
            state      <= IDLE;
            vld_q      <= 1'b0;
        end
    end

    // Coefficient index advances once per completed coefficient.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            coef_q <= '0;
        end else if (last_hs) begin
            coef_q <= (coef_q == COEF_MAX) ? '0 : coef_q + COEF_W'(1);
        end
    end

    assign bus.in_rdy        = in_rdy;
    assign bus.out_vld       = vld_q;
    assign bus.out_digit     = digit_q;
    assign bus.out_lvl       = lvl_q;
    assign bus.out_coef      = coef_q;
    assign bus.out_last_lvl  = last_lvl_q;
    assign bus.out_last_coef = last_lvl_q && (coef_q == COEF_MAX);

endmodule

// File: doc/ks_decomp_seq.md
Name: ks_decomp_seq

Overview:
- Keyswitch input-decomposition stage, directly downstream of the PBS sample-extract output and upstream of the KSK multiply-accumulate.
- Takes each 64-bit mask coefficient of the extracted big LWE (GLWE_K*N coefficients), rounds it to KS_L*KS_B_W MSBs and emits KS_L balanced signed digits serially, one per cycle.
- Output digits are tagged with level and coefficient index.
- Throughput: one coefficient per KS_L cycles, with no bubbles between coefficients.

Parameters:
- MOD_Q_W, 64, input coefficient width (modulus 2^MOD_Q_W)
- KS_L, 8, number of decomposition levels
- KS_B_W, 2, decomposition base width in bits (B = 2^KS_B_W)
- IN_COEF_NB, 2048, coefficients per ciphertext (GLWE_K*N); body is not routed through this block

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- in_data  in  MOD_Q_W  mask coefficient mod 2^MOD_Q_W
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- out_digit  out  KS_B_W+1  signed balanced digit, two's complement
- out_lvl  out  $clog2(KS_L)  level index of out_digit (0 = most significant)
- out_coef  out  $clog2(IN_COEF_NB)  coefficient index within ciphertext
- out_last_lvl  out  1  digit is the final one emitted for this coefficient (level 0)
- out_last_coef  out  1  final digit of final coefficient of the ciphertext
- out_vld  out  1  output valid
- out_rdy  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release) values:
  - FSM in IDLE.
  - out_vld=0, out_digit=0, out_lvl=0, out_coef=0, out_last_lvl=0, out_last_coef=0.
  - Coefficient counter=0, carry=0.
  - in_rdy=1 after reset is released.
- Rounding at accept:
  - R = in_data[MOD_Q_W-1 -: KS_L*KS_B_W] + in_data[MOD_Q_W-KS_L*KS_B_W-1], computed mod 2^(KS_L*KS_B_W).
  - The overflow bit is discarded (wrap to 0).
  - R is stored in a shift register.
- Digit generation, least-significant level first (out_lvl = KS_L-1 down to 0):
  - c = R chunk for the level; d = c + carry, range 0..B.
  - If d >= B/2: digit = d-B, carry=1. Else: digit = d, carry=0.
  - Digit range is [-B/2, B/2-1].
  - The carry out of level 0 is discarded (mod-q wrap).
  - Carry is cleared at each new coefficient accept.
- FSM:
  - IDLE:
    - in_rdy=1, out_vld=0.
    - in_vld → accept; first digit (level KS_L-1) is registered on the next cycle; go to EMIT.
  - EMIT:
    - out_vld=1 and all out_* are stable while out_rdy=0.
    - out_rdy=1 and not last level → advance to the next level the following cycle.
  - At the last level with out_rdy=1:
    - in_rdy is asserted combinationally in that same cycle.
    - If in_vld=1, the next coefficient is loaded and stays in EMIT (zero bubble).
    - Otherwise go to IDLE.
    - in_rdy=0 in all other EMIT cycles.
- Latency: accept cycle t → first digit valid at t+1.
  - With no backpressure, digits occupy t+1..t+KS_L.
- Coefficient counter:
  - Increments at handshake of out_last_lvl.
  - Wraps IN_COEF_NB-1 → 0.
  - out_last_coef = out_last_lvl && out_coef==IN_COEF_NB-1.
- in_data is sampled only on an accepting handshake; in_data changes while in_rdy=0 are ignored.
- Reset mid-coefficient:
  - All state clears immediately.
  - The partial coefficient is dropped with no further out_vld.
  - The counter restarts at 0.

Decomposition:
- Shared package:
  - digit typedef logic signed [KS_B_W:0]
  - KS_DECOMP_W = KS_L*KS_B_W
  - ROUND_BIT = MOD_Q_W-KS_DECOMP_W-1
  - FSM enum {IDLE, EMIT}
  - KS_L, KS_B_W and MOD_Q_W come from the TFHE parameter package.
  - The package also holds a helper function for balanced digit + carry.
- Sub-module:
  - ks_decomp_digit: combinational chunk+carry → (digit, carry_out).
  - It is instantiated once and shared by all levels through the shift register.

Test Plan:
- in_data=0 → 8 digits all 0; out_lvl 7..0; out_last_lvl only on lvl 0.
- in_data=0x0001_0000_0000_0000 → lvl7=+1, others 0. in_data=0x0000_8000_0000_0000 (round bit only) → identical result.
- in_data=0x0002_0000_0000_0000 → lvl7=-2, lvl6=+1, rest 0. in_data=0xFFFF_0000_0000_0000 → lvl7=-1, rest 0. in_data=0xFFFF_8000_0000_0000 → R wraps to 0, all digits 0.
- Continuous in_vld with out_rdy=1 for 3 coefficients → 24 consecutive out_vld cycles, no gap. in_rdy high only on each lvl-0 cycle.
- out_rdy toggled randomly → out_* held stable during stalls; digit sequence matches a reference model.
- Stream 2049 coefficients → out_last_coef on coef 2047 lvl 0; out_coef wraps to 0. Assert a_rst_n low mid-coefficient (lvl 4) → out_vld=0 immediately; after release the next accepted coefficient reports out_coef=0.
